// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit ripple slice per stage, carry registered between slices.
// Latency WIDTH/CHUNK cycles; no output handshake, a global stall freezes every register.
module pipe_addsub #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             in_valid,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("pipe_addsub: WIDTH must be a multiple of CHUNK");
  end

  // Stage registers: full operand skew, partially built sum, carry-out, valid.
  logic [WIDTH-1:0]  a_q  [STAGES];
  logic [WIDTH-1:0]  bx_q [STAGES];
  logic [WIDTH-1:0]  s_q  [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;
  logic              ovf_q;
  logic              zero_q;

  // Stage inputs (previous stage registers, or the ports for stage 0).
  logic [WIDTH-1:0]  ia   [STAGES];
  logic [WIDTH-1:0]  ibx  [STAGES];
  logic [WIDTH-1:0]  is   [STAGES];
  logic [STAGES-1:0] ic;
  logic [STAGES-1:0] iv;

  logic [CHUNK:0]    part [STAGES];
  logic [WIDTH-1:0]  s_d  [STAGES];
  logic [STAGES-1:0] c_d;
  logic              ovf_d;
  logic              zero_d;

  always_comb begin
    ia[0]  = A;
    ibx[0] = sub ? ~B : B;
    is[0]  = '0;
    ic     = '0;
    iv     = '0;
    ic[0]  = sub;
    iv[0]  = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      ia[k]  = a_q[k-1];
      ibx[k] = bx_q[k-1];
      is[k]  = s_q[k-1];
      ic[k]  = c_q[k-1];
      iv[k]  = v_q[k-1];
    end
    c_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      part[k] = {1'b0, ia[k][k*CHUNK +: CHUNK]}
              + {1'b0, ibx[k][k*CHUNK +: CHUNK]}
              + (CHUNK+1)'(ic[k]);
      s_d[k]                  = is[k];
      s_d[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
      c_d[k]                  = part[k][CHUNK];
    end
    ovf_d  = (ia[LAST][WIDTH-1] == ibx[LAST][WIDTH-1]) &&
             (s_d[LAST][WIDTH-1] != ia[LAST][WIDTH-1]);
    zero_d = (s_d[LAST] == '0);
  end

  // Data registers load only with a valid op, so the last stage holds its
  // result across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]  <= '0;
        bx_q[k] <= '0;
        s_q[k]  <= '0;
      end
    end else if (!stall) begin
      v_q <= iv;
      for (int k = 0; k < STAGES; k++) begin
        if (iv[k]) begin
          a_q[k]  <= ia[k];
          bx_q[k] <= ibx[k];
          s_q[k]  <= s_d[k];
          c_q[k]  <= c_d[k];
        end
      end
      if (iv[LAST]) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign out_valid = v_q[LAST];
  assign res       = s_q[LAST];
  assign carry     = c_q[LAST];
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed bench for pipe_addsub (64/16) plus random sweeps of 32/32 and 32/8 instances.
module tb_pipe_addsub;

  logic        clk = 1'b0;
  logic        rst, stall, in_valid, sub;
  logic [63:0] a, b;
  logic        out_valid, carry, overflow, zero;
  logic [63:0] res;

  logic        sv, ssub;
  logic [31:0] sa, sb;
  logic        v32, c32, o32, z32, v8, c8, o8, z8;
  logic [31:0] r32, r8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_addsub #(.WIDTH(64), .CHUNK(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .sub(sub),
    .A(a), .B(b), .out_valid(out_valid), .res(res), .carry(carry),
    .overflow(overflow), .zero(zero));

  pipe_addsub #(.WIDTH(32), .CHUNK(32)) d32 (
    .clk(clk), .rst(rst), .stall(1'b0), .in_valid(sv), .sub(ssub),
    .A(sa), .B(sb), .out_valid(v32), .res(r32), .carry(c32),
    .overflow(o32), .zero(z32));

  pipe_addsub #(.WIDTH(32), .CHUNK(8)) d8 (
    .clk(clk), .rst(rst), .stall(1'b0), .in_valid(sv), .sub(ssub),
    .A(sa), .B(sb), .out_valid(v8), .res(r8), .carry(c8),
    .overflow(o8), .zero(z8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {out_valid, carry, overflow, zero, res}
  function automatic logic [67:0] pk(input logic v, c, o, z, input logic [63:0] r);
    return {v, c, o, z, r};
  endfunction

  task automatic issue(input logic [63:0] x, input logic [63:0] y, input logic s);
    a = x; b = y; sub = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Reference for the 32-bit sweeps, built from signed/unsigned arithmetic.
  function automatic logic [67:0] ref32(input logic [31:0] x, y, input logic s);
    longint sx, sy, sr;
    longint unsigned ux, uy;
    logic [31:0] r;
    logic c, o;
    sx = longint'($signed(x)); sy = longint'($signed(y));
    ux = longint'(x);          uy = longint'(y);
    sr = s ? sx - sy : sx + sy;
    o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    c  = s ? (ux >= uy) : ((ux + uy) > 64'd4294967295);
    r  = s ? x - y : x + y;
    return pk(1'b1, c, o, (r == 32'd0), {32'd0, r});
  endfunction

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    logic [67:0] e;
    rst = 1'b1; stall = 1'b0; in_valid = 1'b0; sub = 1'b0; a = '0; b = '0;
    sv = 1'b0; ssub = 1'b0; sa = '0; sb = '0;
    tick();
    chk("reset_state", pk(out_valid, carry, overflow, zero, res), 68'd0);
    tick();
    rst = 1'b0;
    tick();

    // Carry ripples through all four chunks.
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    tick(); tick();
    chk("not_early", {67'd0, out_valid}, 68'd0);
    tick();
    chk("all_ones_plus_1", pk(out_valid, carry, overflow, zero, res), pk(1, 1, 0, 1, 64'd0));

    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    tick(); tick(); tick();
    chk("signed_ovf", pk(out_valid, carry, overflow, zero, res),
        pk(1, 0, 1, 0, 64'h8000_0000_0000_0000));

    issue(64'd5, 64'd7, 1'b1);
    tick(); tick(); tick();
    chk("5_minus_7", pk(out_valid, carry, overflow, zero, res),
        pk(1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE));

    issue(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1);
    tick(); tick(); tick();
    chk("a_minus_a", pk(out_valid, carry, overflow, zero, res), pk(1, 1, 0, 1, 64'd0));

    issue(64'h8000_0000_0000_0000, 64'd0, 1'b1);
    tick(); tick(); tick();
    chk("sub_zero", pk(out_valid, carry, overflow, zero, res),
        pk(1, 1, 0, 0, 64'h8000_0000_0000_0000));

    // Back-to-back then a single bubble.
    for (int i = 1; i <= 4; i++) begin
      a = 64'(i); b = 64'(i); sub = 1'b0; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("b2b_1", {out_valid, res}, {1'b1, 64'd2});
    tick();
    chk("b2b_2", {out_valid, res}, {1'b1, 64'd4});
    a = 64'd5; b = 64'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("b2b_3", {out_valid, res}, {1'b1, 64'd6});
    tick();
    chk("b2b_4", {out_valid, res}, {1'b1, 64'd8});
    tick();
    chk("bubble_hold", {out_valid, res}, {1'b0, 64'd8});
    tick();
    chk("after_bubble", {out_valid, res}, {1'b1, 64'd10});
    tick(); tick(); tick(); tick();

    // Stall for 5 cycles with 3 ops in flight; a stray op during stall is ignored.
    issue(64'd10, 64'd1, 1'b0);
    issue(64'd20, 64'd2, 1'b0);
    issue(64'd30, 64'd3, 1'b0);
    stall = 1'b1; a = 64'd999; b = 64'd999; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall_frozen_%0d", i), {out_valid, res}, {1'b0, 64'd10});
    end
    in_valid = 1'b0; stall = 1'b0;
    tick();
    chk("stall_r1", {out_valid, res}, {1'b1, 64'd11});
    tick();
    chk("stall_r2", {out_valid, res}, {1'b1, 64'd22});
    tick();
    chk("stall_r3", {out_valid, res}, {1'b1, 64'd33});
    tick();
    chk("stall_end", {out_valid, res}, {1'b0, 64'd33});

    // Asynchronous reset with two ops in flight.
    issue(64'd1, 64'd1, 1'b0);
    issue(64'd2, 64'd2, 1'b0);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("async_rst", pk(out_valid, carry, overflow, zero, res), 68'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("post_rst_quiet_%0d", i), {67'd0, out_valid}, 68'd0);
    end
    issue(64'd3, 64'd4, 1'b0);
    tick(); tick(); tick();
    chk("post_rst_op", {out_valid, res}, {1'b1, 64'd7});

    // Random sweeps of the 32-bit variants.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom(); rb = $urandom(); rs = 1'($urandom_range(0, 1));
      if (i == 0) begin ra = 32'h7FFF_FFFF; rb = 32'h8000_0000; rs = 1'b1; end
      if (i == 1) begin ra = 32'hFFFF_FFFF; rb = 32'd1;         rs = 1'b0; end
      e = ref32(ra, rb, rs);
      sa = ra; sb = rb; ssub = rs; sv = 1'b1;
      tick();
      sv = 1'b0;
      chk("sweep_32x32", pk(v32, c32, o32, z32, {32'd0, r32}), e);
      tick(); tick(); tick();
      chk("sweep_32x8", pk(v8, c8, o8, z8, {32'd0, r8}), e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_addsub.md
Name: pipe_addsub

Overview:
Parametrised, pipelined integer adder/subtractor that generalises the combinational 64-bit adder. Splits a WIDTH-bit add into WIDTH/CHUNK ripple stages, one per clock, with registered carry between stages. Accepts one operation per cycle and supports a global stall. Produces result, carry, signed overflow and zero flags. Sits between the EX-stage operand muxes and the EX/MEM register for wide or multi-cycle arithmetic.

Parameters:
WIDTH, 64, operand/result width in bits.
CHUNK, 16, bits added per pipeline stage. WIDTH % CHUNK == 0 is required; STAGES = WIDTH/CHUNK.

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  asynchronous active-high reset.
stall  in  1  1 = every pipeline register holds its value.
in_valid  in  1  operands valid this cycle.
sub  in  1  0 = A+B, 1 = A-B (A + ~B + 1).
A  in  WIDTH  operand A.
B  in  WIDTH  operand B.
out_valid  out  1  res/flags valid.
res  out  WIDTH  sum/difference modulo 2^WIDTH.
carry  out  1  carry out of MSB; for sub, 1 = no borrow.
overflow  out  1  two's-complement signed overflow.
zero  out  1  res == 0.

Behaviour:
- Reset (async, rst=1): all stage valid bits, partial results, carries and delayed operand bits go to 0 immediately. out_valid=0, res=0, carry=0, overflow=0, zero=0. Deassertion is sampled at the next clk edge.
- Operand preparation: Bx = sub ? ~B : B; cin0 = sub.
- Stage k (0..STAGES-1) computes bits [k*CHUNK +: CHUNK] = A_k + Bx_k + cin_k and registers the chunk sum and carry-out. Upper unprocessed chunks of A and Bx, plus already-computed lower sum chunks, travel in skew registers alongside. The sign bits A[MSB] and Bx[MSB] travel too, for overflow.
- Latency: exactly STAGES cycles from an accepted in_valid (rising edge with stall=0) to out_valid=1. With CHUNK==WIDTH, latency is 1.
- Throughput: one op per non-stalled cycle. Back-to-back operations never interfere; each stage carries its own valid bit.
- Final flags are registered with res:
  - carry = carry-out of the top chunk.
  - overflow = (A[MSB]==Bx[MSB]) && (res[MSB]!=A[MSB]).
  - zero = (res==0).
- in_valid=0: a bubble (valid=0) propagates. Bubble data registers may hold don't-care values, but when out_valid=0, res, carry, overflow and zero must be held at their previous values.
- stall=1: no register changes, including valid bits; in_valid/A/B/sub are ignored that cycle. out_valid and res stay stable throughout the stall. There is no output handshake; the consumer drives stall.
- Stall and reset together: reset wins.
- Reset mid-operation: all in-flight ops are discarded; no out_valid for them after reset.
- Wrap-around: results are modulo 2^WIDTH, with no saturation.
- sub with B=0: carry=1, overflow=0. sub with A=B: res=0, zero=1, carry=1.

Test Plan:
- Defaults, stall=0, in_valid pulse: A=64'hFFFF_FFFF_FFFF_FFFF, B=1, sub=0 -> 4 cycles later out_valid=1, res=0, carry=1, overflow=0, zero=1. This checks carry propagation across all chunks.
- A=64'h7FFF_FFFF_FFFF_FFFF, B=1, sub=0 -> res=64'h8000_0000_0000_0000, overflow=1, carry=0, zero=0. Then A=5, B=7, sub=1 -> res=64'hFFFF_FFFF_FFFF_FFFE, carry=0, overflow=0.
- Back-to-back, 4 consecutive in_valid ops (i+i for i=1..4) -> out_valid high on 4 consecutive cycles with res 2, 4, 6, 8 in order. A single in_valid gap produces exactly one out_valid=0 cycle.
- Stall: issue 3 ops, hold stall=1 for 5 cycles mid-flight -> outputs frozen during the stall; results appear in order after release with total latency 4 + 5.
- Reset mid-flight: issue 2 ops, assert rst asynchronously between edges -> outputs go to 0 immediately, and no out_valid appears afterwards until new ops are issued.
- Parameter sweep: WIDTH=32, CHUNK=32 (latency 1) and WIDTH=32, CHUNK=8 (latency 4). Run 1000 random A/B/sub each against a reference model, checking res/carry/overflow/zero exactly.
